// File: rtl/slapfight_dl_router.sv
// ioctl download router: ROM bytes to region write ports through a one-entry skid,
// plus DIP / PCB-select capture and download statistics.
module slapfight_dl_router #(
    parameter int                  NREG  = 4,
    parameter int                  AW    = 25,
    parameter logic [NREG*AW-1:0]  RBASE = {25'h30000, 25'h20000, 25'h10000, 25'h0}
) (
    input  logic            clkm_48MHZ,
    input  logic            RESET_n,
    input  logic            ioctl_download,
    input  logic [7:0]      ioctl_index,
    input  logic            ioctl_wr,
    input  logic [AW-1:0]   ioctl_addr,
    input  logic [7:0]      ioctl_dout,
    output logic            ioctl_wait,
    output logic [NREG-1:0] dn_wr,
    output logic [AW-1:0]   dn_addr,
    output logic [7:0]      dn_data,
    input  logic            dn_ready,
    output logic [63:0]     dip_sw,
    output logic            pcb_sel,
    output logic [AW-1:0]   dl_bytes,
    output logic [7:0]      dl_sum,
    output logic            dl_done
);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, DONE} state_t;

    state_t        state_q, state_d;
    logic          pend_q;
    logic [2:0]    reg_q;
    logic          hit;
    logic [2:0]    ridx;
    logic [AW-1:0] rel;
    logic          accept;
    logic          capture;
    logic          rom_wr;

    // Bases ascend, so the last matching region is the highest one.
    always_comb begin
        hit  = 1'b0;
        ridx = '0;
        rel  = '0;
        for (int i = 0; i < NREG; i++) begin
            if (ioctl_addr >= RBASE[i*AW +: AW]) begin
                hit  = 1'b1;
                ridx = 3'(i);
                rel  = ioctl_addr - RBASE[i*AW +: AW];
            end
        end
    end

    assign accept = pend_q & dn_ready;
    assign rom_wr = ioctl_wr & ioctl_download & (ioctl_index == 8'd0) & hit;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ioctl_download && ioctl_index == 8'd0)
                    state_d = LOAD;
            end
            LOAD: begin
                if (pend_q && !dn_ready)
                    state_d = HOLD;
                else if (!ioctl_download)
                    state_d = DONE;
                else
                    capture = rom_wr;
            end
            HOLD: begin
                if (dn_ready)
                    state_d = ioctl_download ? LOAD : DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dn_wr = '0;
        for (int i = 0; i < NREG; i++)
            dn_wr[i] = pend_q && (reg_q == 3'(i));
    end

    assign ioctl_wait = (state_q == HOLD);
    assign dl_done    = (state_q == DONE);

    always_ff @(posedge clkm_48MHZ) begin
        if (!RESET_n) begin
            state_q  <= IDLE;
            pend_q   <= 1'b0;
            reg_q    <= '0;
            dn_addr  <= '0;
            dn_data  <= '0;
            dip_sw   <= '0;
            pcb_sel  <= 1'b0;
            dl_bytes <= '0;
            dl_sum   <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                pend_q  <= 1'b1;
                reg_q   <= ridx;
                dn_addr <= rel;
                dn_data <= ioctl_dout;
            end else if (accept) begin
                pend_q <= 1'b0;
            end
            if (state_q == IDLE && state_d == LOAD) begin
                dl_bytes <= '0;
                dl_sum   <= '0;
            end else if (accept) begin
                dl_bytes <= dl_bytes + 1'b1;
                dl_sum   <= dl_sum + dn_data;
            end
            if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr[AW-1:3] == '0)
                dip_sw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
            if (ioctl_wr && ioctl_index == 8'd1)
                pcb_sel <= (ioctl_dout == 8'h01);
        end
    end

endmodule

// File: tb/tb_slapfight_dl_router.sv
// Randomized bench for slapfight_dl_router against a transaction-level model,
// with directed scenarios pinned by literal expectations.
module tb_slapfight_dl_router;

    localparam logic [24:0] BASE [4] = '{25'h0, 25'h10000, 25'h20000, 25'h30000};

    logic        clk;
    logic        RESET_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [3:0]  dn_wr;
    logic [24:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_ready;
    logic [63:0] dip_sw;
    logic        pcb_sel;
    logic [24:0] dl_bytes;
    logic [7:0]  dl_sum;
    logic        dl_done;

    slapfight_dl_router dut (
        .clkm_48MHZ     (clk),
        .RESET_n        (RESET_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .dn_wr          (dn_wr),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_ready       (dn_ready),
        .dip_sw         (dip_sw),
        .pcb_sel        (pcb_sel),
        .dl_bytes       (dl_bytes),
        .dl_sum         (dl_sum),
        .dl_done        (dl_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit en      = 1'b0;
    int done_cnt = 0;
    int wait_cnt = 0;
    int wr1_cnt  = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    endtask

    // Model: a session flag, one outstanding write, a refused-write flag and a done pulse.
    bit          m_active, m_pend, m_stall, m_done, m_pcb;
    int          m_reg;
    logic [24:0] m_addr, m_bytes;
    logic [7:0]  m_data, m_sum;
    logic [7:0]  m_dip [8];

    function automatic int region(input logic [24:0] a);
        int r = -1;
        for (int i = 0; i < 4; i++) if (a >= BASE[i]) r = i;
        return r;
    endfunction

    always @(posedge clk) begin
        int r;
        if (!RESET_n) begin
            m_active = 0; m_pend = 0; m_stall = 0; m_done = 0; m_pcb = 0;
            m_reg = 0; m_addr = 0; m_data = 0; m_bytes = 0; m_sum = 0;
            for (int k = 0; k < 8; k++) m_dip[k] = 8'h00;
        end else begin
            if (m_pend && dn_ready) begin
                m_bytes = m_bytes + 25'd1;
                m_sum   = m_sum + m_data;
            end
            if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'd8)
                m_dip[ioctl_addr[2:0]] = ioctl_dout;
            if (ioctl_wr && ioctl_index == 8'd1)
                m_pcb = (ioctl_dout == 8'h01);
            if (m_done) begin
                m_done = 0;
            end else if (!m_active) begin
                if (ioctl_download && ioctl_index == 8'd0) begin
                    m_active = 1; m_bytes = 0; m_sum = 0;
                end
            end else if (m_stall) begin
                if (dn_ready) begin
                    m_pend = 0; m_stall = 0;
                    if (!ioctl_download) begin m_active = 0; m_done = 1; end
                end
            end else if (m_pend && !dn_ready) begin
                m_stall = 1;
            end else begin
                m_pend = 0;
                r = region(ioctl_addr);
                if (!ioctl_download) begin
                    m_active = 0; m_done = 1;
                end else if (ioctl_wr && ioctl_index == 8'd0 && r >= 0) begin
                    m_pend = 1; m_reg = r;
                    m_addr = ioctl_addr - BASE[r];
                    m_data = ioctl_dout;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0]  ewr;
        logic [63:0] edip;
        if (en) begin
            ewr = m_pend ? 4'(1 << m_reg) : 4'b0000;
            for (int k = 0; k < 8; k++) edip[k*8 +: 8] = m_dip[k];
            chk("dn_wr", 64'(dn_wr), 64'(ewr));
            if (ewr != 4'b0000) begin
                chk("dn_addr", 64'(dn_addr), 64'(m_addr));
                chk("dn_data", 64'(dn_data), 64'(m_data));
            end
            chk("ioctl_wait", 64'(ioctl_wait), 64'(m_stall));
            chk("dl_done", 64'(dl_done), 64'(m_done));
            chk("dl_bytes", 64'(dl_bytes), 64'(m_bytes));
            chk("dl_sum", 64'(dl_sum), 64'(m_sum));
            chk("dip_sw", dip_sw, edip);
            chk("pcb_sel", 64'(pcb_sel), 64'(m_pcb));
            if (dl_done) done_cnt++;
            if (ioctl_wait) wait_cnt++;
            if (dn_wr == 4'b0001) wr1_cnt++;
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        ioctl_index = idx; ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
        cyc(1);
        ioctl_wr = 1'b0;
    endtask

    initial begin
        RESET_n = 0; ioctl_download = 0; ioctl_index = 0; ioctl_wr = 0;
        ioctl_addr = 0; ioctl_dout = 0; dn_ready = 1;
        cyc(1);
        en = 1'b1;
        cyc(2);
        RESET_n = 1;
        @(negedge clk);
        chk("rst_dn_wr", 64'(dn_wr), 64'd0);
        chk("rst_wait", 64'(ioctl_wait), 64'd0);
        chk("rst_bytes", 64'(dl_bytes), 64'd0);
        chk("rst_dip", dip_sw, 64'd0);
        cyc(1);

        // T1: sixteen bytes into region 0
        done_cnt = 0; wr1_cnt = 0;
        ioctl_download = 1; ioctl_index = 0; cyc(1);
        for (int a = 0; a < 16; a++) begin
            wr_byte(8'd0, 25'(a), 8'(a));
            cyc(1);
        end
        ioctl_download = 0; cyc(4);
        @(negedge clk);
        chk("t1_bytes", 64'(dl_bytes), 64'd16);
        chk("t1_sum", 64'(dl_sum), 64'h78);
        chk("t1_done", 64'(done_cnt), 64'd1);
        chk("t1_wr_cycles", 64'(wr1_cnt), 64'd16);

        // T2: region decode at interior and top-of-map addresses
        ioctl_download = 1; cyc(1);
        wr_byte(8'd0, 25'h10005, 8'h33);
        @(negedge clk);
        chk("t2_wr_r1", 64'(dn_wr), 64'b0010);
        chk("t2_addr_r1", 64'(dn_addr), 64'h5);
        cyc(1);
        wr_byte(8'd0, 25'h3FFFF, 8'h44);
        @(negedge clk);
        chk("t2_wr_r3", 64'(dn_wr), 64'b1000);
        chk("t2_addr_r3", 64'(dn_addr), 64'hFFFF);
        cyc(1);
        ioctl_download = 0; cyc(4);

        // T3: three-cycle stall on the second write
        ioctl_download = 1; cyc(1);
        wr_byte(8'd0, 25'h100, 8'h10); cyc(1);
        wait_cnt = 0;
        wr_byte(8'd0, 25'h101, 8'h20);
        dn_ready = 0; cyc(2);
        @(negedge clk);
        chk("t3_data_held", 64'(dn_data), 64'h20);
        cyc(1);
        dn_ready = 1; cyc(3);
        ioctl_download = 0; cyc(4);
        @(negedge clk);
        chk("t3_wait_cycles", 64'(wait_cnt), 64'd3);
        chk("t3_bytes", 64'(dl_bytes), 64'd2);
        chk("t3_sum", 64'(dl_sum), 64'h30);

        // T4: download ends while a write is stalled
        ioctl_download = 1; cyc(1);
        done_cnt = 0;
        wr_byte(8'd0, 25'h20, 8'h44);
        dn_ready = 0; cyc(1);
        ioctl_download = 0; cyc(3);
        @(negedge clk);
        chk("t4_no_early_done", 64'(done_cnt), 64'd0);
        dn_ready = 1; cyc(4);
        @(negedge clk);
        chk("t4_done", 64'(done_cnt), 64'd1);
        chk("t4_bytes", 64'(dl_bytes), 64'd1);

        // T5: DIP and PCB-select capture
        ioctl_download = 1; ioctl_index = 8'd254; cyc(1);
        wr_byte(8'd254, 25'd1, 8'hA5); cyc(1);
        wr_byte(8'd254, 25'd9, 8'h11); cyc(1);
        ioctl_index = 8'd1;
        wr_byte(8'd1, 25'd0, 8'h01); cyc(1);
        ioctl_download = 0; cyc(1);
        @(negedge clk);
        chk("t5_dip_byte1", 64'(dip_sw[15:8]), 64'hA5);
        chk("t5_dip_all", dip_sw, 64'h0000_0000_0000_A500);
        chk("t5_pcb", 64'(pcb_sel), 64'd1);

        // T6: reset while stalled
        ioctl_index = 0; ioctl_download = 1; cyc(1);
        wr_byte(8'd0, 25'h7, 8'h07); cyc(1);
        wr_byte(8'd0, 25'h8, 8'h08);
        dn_ready = 0; cyc(2);
        @(negedge clk);
        chk("t6_in_hold", 64'(ioctl_wait), 64'd1);
        RESET_n = 0; ioctl_download = 0; cyc(1);
        @(negedge clk);
        chk("t6_wait", 64'(ioctl_wait), 64'd0);
        chk("t6_dn_wr", 64'(dn_wr), 64'd0);
        chk("t6_bytes", 64'(dl_bytes), 64'd0);
        RESET_n = 1; dn_ready = 1; cyc(2);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            RESET_n = ($urandom_range(0, 599) != 0);
            if (!ioctl_download) begin
                if ($urandom_range(0, 15) == 0) begin
                    ioctl_download = 1;
                    case ($urandom_range(0, 4))
                        3: ioctl_index = 8'd1;
                        4: ioctl_index = 8'd254;
                        default: ioctl_index = 8'd0;
                    endcase
                end
            end else if ($urandom_range(0, 79) == 0) begin
                ioctl_download = 0;
            end
            ioctl_wr = ($urandom_range(0, 2) == 0);
            if (ioctl_index == 8'd254)
                ioctl_addr = 25'($urandom_range(0, 15));
            else if ($urandom_range(0, 3) == 0)
                ioctl_addr = BASE[$urandom_range(0, 3)] + 25'($urandom_range(0, 3)) - 25'd2;
            else
                ioctl_addr = 25'($urandom_range(0, 'h4FFFF));
            ioctl_dout = 8'($urandom);
            dn_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        ioctl_wr = 0; ioctl_download = 0; dn_ready = 1; RESET_n = 1;
        cyc(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
